// File: rtl/tx_crc16_serializer_if.sv
// Packet source / serial sink bundle for tx_crc16_serializer.
interface tx_crc16_serializer_if;
    logic        tx_start;
    logic        tx_zlp;
    logic        tx_abort;
    logic        bit_en;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_last;
    logic        tx_data_ready;
    logic        tx_bit;
    logic        tx_bit_valid;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_underrun;
    logic [15:0] crc_out;

    modport master (
        output tx_start, tx_zlp, tx_abort, bit_en, tx_data, tx_data_valid, tx_last,
        input  tx_data_ready, tx_bit, tx_bit_valid, tx_busy, tx_done, tx_underrun, crc_out
    );

    modport slave (
        input  tx_start, tx_zlp, tx_abort, bit_en, tx_data, tx_data_valid, tx_last,
        output tx_data_ready, tx_bit, tx_bit_valid, tx_busy, tx_done, tx_underrun, crc_out
    );
endinterface

// File: rtl/tx_crc16_serializer.sv
// Byte-to-serial packet transmitter: payload LSB-first, then CRC-16 (0x8005) MSB-first.
module tx_crc16_serializer (
    input  logic                  clk,
    input  logic                  n_rst,
    tx_crc16_serializer_if.slave  bus
);
    localparam int unsigned CRC_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CRC_W-1:0] POLY = 16'h8005;

    typedef enum logic [2:0] {IDLE, LOAD, DATA, CRC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                bit_q, bit_d;
    logic                bit_valid_q, bit_valid_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                underrun_q, underrun_d;
    logic                crc_inv;

    // State and datapath registers; outputs are registered from the next-state view
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            crc_q       <= '0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign crc_inv = shift_q[0] ^ crc_q[CRC_W-1];

    // Next-state, datapath and registered-output decode; abort freezes CRC and returns to IDLE
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        shift_d    = shift_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        underrun_d = 1'b0;

        if (bus.tx_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tx_start) begin
                        crc_d   = '0;
                        cnt_d   = '0;
                        state_d = bus.tx_zlp ? CRC : LOAD;
                    end
                end
                LOAD: begin
                    if (bus.tx_data_valid) begin
                        shift_d = bus.tx_data;
                        last_d  = bus.tx_last;
                        cnt_d   = '0;
                        state_d = DATA;
                    end else if (bus.bit_en) begin
                        underrun_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                DATA: begin
                    if (bus.bit_en) begin
                        shift_d = {1'b0, shift_q[BYTE_W-1:1]};
                        crc_d   = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_inv ? POLY : '0);
                        if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                            cnt_d   = '0;
                            state_d = last_q ? CRC : LOAD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                CRC: begin
                    if (bus.bit_en) begin
                        crc_d = {crc_q[CRC_W-2:0], 1'b0};
                        if (cnt_q == CNT_W'(CRC_W - 1)) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        bit_valid_d = (state_d == DATA) || (state_d == CRC);
        bit_d       = (state_d == DATA) ? shift_d[0] :
                      (state_d == CRC)  ? crc_d[CRC_W-1] : 1'b0;
        ready_d     = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    assign bus.tx_bit        = bit_q;
    assign bus.tx_bit_valid  = bit_valid_q;
    assign bus.tx_data_ready = ready_q;
    assign bus.tx_busy       = busy_q;
    assign bus.tx_done       = done_q;
    assign bus.tx_underrun   = underrun_q;
    assign bus.crc_out       = crc_q;
endmodule

// File: tb/tb_tx_crc16_serializer.sv
// Self-checking bench for tx_crc16_serializer against a bit-stream/CRC reference model.
module tb_tx_crc16_serializer;
    logic clk;
    logic n_rst;
    tx_crc16_serializer_if bus ();

    tx_crc16_serializer dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  pkt[$];
    bit          got[$];
    logic [15:0] crc_at_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: polynomial division of the message bit stream by x^16+x^15+x^2+1
    function automatic logic [15:0] crc_of(input bit bits[$]);
        logic [15:0] c;
        c = 16'h0000;
        foreach (bits[i]) begin
            if ((bits[i] ^ c[15]) == 1'b1) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                           c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic idle_inputs();
        bus.tx_start = 1'b0; bus.tx_zlp = 1'b0; bus.tx_abort = 1'b0; bus.bit_en = 1'b0;
        bus.tx_data = 8'h00; bus.tx_data_valid = 1'b0; bus.tx_last = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},      32'(bus.tx_busy),       32'd0);
        check({tag, " bit_valid"}, 32'(bus.tx_bit_valid),  32'd0);
        check({tag, " bit"},       32'(bus.tx_bit),        32'd0);
        check({tag, " ready"},     32'(bus.tx_data_ready), 32'd0);
    endtask

    // Sends pkt (or a ZLP); ur_byte>=0 withholds that byte, abort_bit>=0 aborts on that CRC bit
    task automatic run_packet(input string tag, input bit zlp, input int period,
                              input int ur_byte, input int abort_bit, input bit start_mid);
        bit          exp_bits[$];
        bit          pre_bits[$];
        logic [15:0] exp_crc, exp_final;
        logic [7:0]  byt;
        int n, idx, ready_cnt, done_cnt, ur_cnt, cyc, abort_cyc, fin_cyc;
        int exp_nbits, exp_ready, exp_done, exp_ur;
        bit finished, aborted, crc_checked;

        n = zlp ? 0 : pkt.size();
        idx = 0; ready_cnt = 0; done_cnt = 0; ur_cnt = 0; cyc = 0;
        abort_cyc = -10; fin_cyc = -1;
        finished = 1'b0; aborted = 1'b0; crc_checked = 1'b0;
        got.delete();

        for (int b = 0; b < n; b++) begin
            byt = pkt[b];
            for (int k = 0; k < 8; k++) exp_bits.push_back(byt[k]);
        end
        exp_crc = crc_of(exp_bits);
        for (int k = 15; k >= 0; k--) exp_bits.push_back(exp_crc[k]);

        if (ur_byte >= 0) begin
            for (int i = 0; i < 8 * ur_byte; i++) pre_bits.push_back(exp_bits[i]);
            exp_nbits = 8 * ur_byte; exp_ready = ur_byte; exp_done = 0; exp_ur = 1;
            exp_final = crc_of(pre_bits);
        end else if (abort_bit >= 0) begin
            exp_nbits = 8 * n + abort_bit; exp_ready = n; exp_done = 0; exp_ur = 0;
            exp_final = exp_crc << abort_bit;
        end else begin
            exp_nbits = 8 * n + 16; exp_ready = n; exp_done = 1; exp_ur = 0;
            exp_final = 16'h0000;
        end

        @(posedge clk); #1;
        bus.tx_start = 1'b1; bus.tx_zlp = zlp;
        @(posedge clk); #1;
        bus.tx_start = 1'b0; bus.tx_zlp = 1'b0;

        while (!finished && cyc < 2000) begin
            bus.bit_en        = (cyc % period) == (period - 1);
            bus.tx_data_valid = (idx < n) && (idx != ur_byte);
            bus.tx_data       = (idx < n) ? pkt[idx] : 8'h00;
            bus.tx_last       = (idx == n - 1);
            bus.tx_abort      = (abort_bit >= 0) && !aborted && bus.bit_en &&
                                (got.size() == 8 * n + abort_bit);
            bus.tx_start      = start_mid && (got.size() == 3);
            @(negedge clk);
            if (bus.tx_done)     done_cnt++;
            if (bus.tx_underrun) ur_cnt++;
            if (!bus.tx_busy) begin
                finished = 1'b1;
                fin_cyc  = cyc;
            end else begin
                if (!crc_checked && got.size() == 8 * n && bus.tx_bit_valid) begin
                    crc_checked = 1'b1;
                    crc_at_data = bus.crc_out;
                    check({tag, " crc_after_data"}, 32'(bus.crc_out), 32'(exp_crc));
                end
                if (bus.bit_en && bus.tx_bit_valid && !bus.tx_abort) begin
                    if (got.size() < exp_bits.size())
                        check($sformatf("%s bit%0d", tag, got.size()), 32'(bus.tx_bit),
                              32'(exp_bits[got.size()]));
                    got.push_back(bus.tx_bit);
                end
                if (bus.tx_data_ready && bus.tx_data_valid) begin
                    idx++;
                    ready_cnt++;
                end
                if (bus.tx_abort) begin
                    aborted   = 1'b1;
                    abort_cyc = cyc;
                end
            end
            cyc++;
            @(posedge clk); #1;
        end
        idle_inputs();

        check({tag, " terminated"}, 32'(finished),    32'd1);
        check({tag, " nbits"},      32'(got.size()),  32'(exp_nbits));
        check({tag, " done_cnt"},   32'(done_cnt),    32'(exp_done));
        check({tag, " underruns"},  32'(ur_cnt),      32'(exp_ur));
        check({tag, " handshakes"}, 32'(ready_cnt),   32'(exp_ready));
        check({tag, " crc_final"},  32'(bus.crc_out), 32'(exp_final));
        check_idle_outputs(tag);
        if (abort_bit >= 0)
            check({tag, " abort_to_idle"}, 32'(fin_cyc - abort_cyc), 32'd1);
        if (exp_done == 1)
            check({tag, " rx_residue"}, 32'(crc_of(got)), 32'd0);
    endtask

    function automatic logic [23:0] stream24();
        logic [23:0] s;
        s = '0;
        for (int i = 0; i < 24 && i < got.size(); i++) s[23 - i] = got[i];
        return s;
    endfunction

    initial begin
        int done_seen, len;
        idle_inputs();
        n_rst = 1'b0;
        #12;
        check("reset crc", 32'(bus.crc_out), 32'd0);
        check("reset done", 32'(bus.tx_done), 32'd0);
        check("reset underrun", 32'(bus.tx_underrun), 32'd0);
        check_idle_outputs("reset");
        @(negedge clk); n_rst = 1'b1;

        // Single byte 0x01
        pkt = '{8'h01};
        run_packet("b01", 1'b0, 4, -1, -1, 1'b0);
        check("b01 stream", 32'(stream24()), 32'(24'b10000000_1000001100000011));
        check("b01 crc_const", 32'(crc_at_data), 32'h8303);

        // Single byte 0x00
        pkt = '{8'h00};
        run_packet("b00", 1'b0, 3, -1, -1, 1'b0);
        check("b00 crc_const", 32'(crc_at_data), 32'h0000);
        check("b00 stream", 32'(stream24()), 32'd0);

        // Zero-length packet
        run_packet("zlp", 1'b1, 2, -1, -1, 1'b0);

        // Underrun at the second byte
        pkt = '{8'h01, 8'h00};
        run_packet("underrun", 1'b0, 4, 1, -1, 1'b0);

        // Abort on the 10th CRC bit, with a stray tx_start while busy
        pkt = '{8'($urandom), 8'($urandom)};
        run_packet("abort", 1'b0, 3, -1, 9, 1'b1);

        // Randomized packets
        for (int p = 0; p < 6; p++) begin
            len = int'($urandom_range(1, 4));
            pkt.delete();
            for (int b = 0; b < len; b++) pkt.push_back(8'($urandom));
            run_packet($sformatf("rand%0d", p), 1'b0, int'($urandom_range(1, 4)), -1, -1, 1'b0);
        end

        // Asynchronous reset in the middle of DATA
        @(posedge clk); #1;
        bus.tx_start = 1'b1;
        @(posedge clk); #1;
        bus.tx_start = 1'b0; bus.tx_data = 8'hA5; bus.tx_data_valid = 1'b1;
        bus.tx_last = 1'b1; bus.bit_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid busy_before", 32'(bus.tx_busy), 32'd1);
        check("rst_mid bit_valid_before", 32'(bus.tx_bit_valid), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("rst_mid crc", 32'(bus.crc_out), 32'd0);
        check("rst_mid done", 32'(bus.tx_done), 32'd0);
        check("rst_mid underrun", 32'(bus.tx_underrun), 32'd0);
        check_idle_outputs("rst_mid");
        idle_inputs();
        @(negedge clk); n_rst = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.bit_en = (c % 2) == 1;
            @(negedge clk);
            if (bus.tx_done || bus.tx_busy) done_seen++;
        end
        idle_inputs();
        check("rst_mid quiet_after", 32'(done_seen), 32'd0);

        pkt = '{8'h01};
        run_packet("b01_again", 1'b0, 4, -1, -1, 1'b0);
        check("b01_again stream", 32'(stream24()), 32'(24'b10000000_1000001100000011));
        check("b01_again crc_const", 32'(crc_at_data), 32'h8303);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
